// File: rtl/rx_sync_pkg.sv
// Shared definitions for the receive-side lane-alignment logic: FSM state
// encoding and the default alignment/idle symbol. Also imported by the
// phy_rx top-level status logic, so the encodings here are part of the
// external state port contract.
package rx_sync_pkg;

  // FSM state encoding (2-bit, exported on the state port)
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // Default alignment / idle symbol
  localparam logic [7:0] COM_DEFAULT = 8'hBC;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; once the count reaches all-ones further increments are ignored.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rx_sync_ctrl.sv
// Lane-alignment controller in front of the phy_rx byte demux.
// SEARCH -> COUNT -> ACTIVE after SYNC_COMS consecutive valid COM bytes
// (gaps with valid_in=0 do not break a run). In ACTIVE only non-COM bytes
// are forwarded, with a one-cycle registered latency. LOSS_CYCLES
// consecutive idle cycles in ACTIVE drop back to SEARCH.
// Optional build macro RX_SYNC_LOSSCNT_EN: when defined, loss_cnt is a
// saturating count of ACTIVE->SEARCH loss events; otherwise it reads 0.
module rx_sync_ctrl
  import rx_sync_pkg::*;
#(
  parameter int unsigned SYNC_COMS   = 4,
  parameter int unsigned LOSS_CYCLES = 16,
  parameter logic [7:0]  COM         = COM_DEFAULT
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sync_active,
  output logic       idle,
  output logic [1:0] state,
  output logic [3:0] loss_cnt
);

  // com_cnt value that, with one more COM, completes the sync run
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COMS - 1);
  // gap_cnt value that, with one more idle cycle, triggers loss of sync
  localparam logic [7:0] GAP_LAST  = 8'(LOSS_CYCLES - 1);

  logic [1:0] state_q,       state_d;
  logic [3:0] com_cnt_q,     com_cnt_d;
  logic [7:0] data_out_q,    data_out_d;
  logic       valid_out_q,   valid_out_d;
  logic       sync_active_q, sync_active_d;
  logic       idle_q,        idle_d;

  logic       is_com;
  logic       in_active;
  logic       loss_hit;
  logic       gap_inc;
  logic       gap_clr;
  logic [7:0] gap_cnt;

  assign is_com    = valid_in && (data_in == COM);
  assign in_active = (state_q == ST_ACTIVE);

  // Loss fires on the idle cycle that completes LOSS_CYCLES gaps; a
  // deasserted enable masks it so no loss is counted in that case.
  assign loss_hit = enable && in_active && !valid_in && (gap_cnt == GAP_LAST);

  // Gap counter only runs on idle cycles in ACTIVE and restarts on any
  // valid byte, on loss, on disable, and whenever sync is not held.
  assign gap_inc = enable && in_active && !valid_in && !loss_hit;
  assign gap_clr = !enable || !in_active || valid_in || loss_hit;

  sat_counter #(
    .W (8)
  ) u_gap_cnt (
    .clk   (clk_4f),
    .rst_n (reset),
    .inc   (gap_inc),
    .clr   (gap_clr),
    .cnt   (gap_cnt)
  );

`ifdef RX_SYNC_LOSSCNT_EN
  // Loss events accumulate until reset; nothing else clears them
  sat_counter #(
    .W (4)
  ) u_loss_cnt (
    .clk   (clk_4f),
    .rst_n (reset),
    .inc   (loss_hit),
    .clr   (1'b0),
    .cnt   (loss_cnt)
  );
`else
  assign loss_cnt = 4'h0;
`endif

  // Next-state and COM run length; enable=0 overrides every transition
  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    if (!enable) begin
      state_d   = ST_SEARCH;
      com_cnt_d = '0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          com_cnt_d = '0;
          if (is_com) begin
            if (SYNC_LAST == 4'd0) begin
              state_d = ST_ACTIVE;
            end else begin
              state_d   = ST_COUNT;
              com_cnt_d = 4'd1;
            end
          end
        end
        ST_COUNT: begin
          if (valid_in) begin
            if (!is_com) begin
              state_d   = ST_SEARCH;
              com_cnt_d = '0;
            end else if (com_cnt_q == SYNC_LAST) begin
              state_d   = ST_ACTIVE;
              com_cnt_d = '0;
            end else begin
              com_cnt_d = com_cnt_q + 4'd1;
            end
          end
        end
        ST_ACTIVE: begin
          com_cnt_d = '0;
          if (loss_hit) begin
            state_d = ST_SEARCH;
          end
        end
        default: begin
          state_d   = ST_SEARCH;
          com_cnt_d = '0;
        end
      endcase
    end
  end

  // Forwarding path: only non-COM bytes seen while already ACTIVE are
  // passed on, so the COM completing sync is never forwarded. data_out
  // holds its last forwarded value otherwise.
  always_comb begin
    data_out_d    = data_out_q;
    valid_out_d   = 1'b0;
    idle_d        = 1'b0;
    sync_active_d = (state_d == ST_ACTIVE);
    if (enable && in_active) begin
      if (valid_in) begin
        if (is_com) begin
          idle_d = 1'b1;
        end else begin
          valid_out_d = 1'b1;
          data_out_d  = data_in;
        end
      end else if (!loss_hit) begin
        idle_d = idle_q;
      end
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_SEARCH;
      com_cnt_q     <= '0;
      data_out_q    <= 8'h00;
      valid_out_q   <= 1'b0;
      sync_active_q <= 1'b0;
      idle_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      com_cnt_q     <= com_cnt_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      sync_active_q <= sync_active_d;
      idle_q        <= idle_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign sync_active = sync_active_q;
  assign idle        = idle_q;
  assign state       = state_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Self-checking bench for rx_sync_ctrl. A behavioural model predicts the
// registered outputs for every driven byte; predictions go into a
// scoreboard queue and are popped and compared once the DUT has clocked.
// Build with +define+RX_SYNC_LOSSCNT_EN to expect a live loss counter.
module tb_rx_sync_ctrl;

  localparam int SYNC_COMS   = 4;
  localparam int LOSS_CYCLES = 16;
  localparam logic [7:0] COM = 8'hBC;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       sync_active;
  logic       idle;
  logic [1:0] state;
  logic [3:0] loss_cnt;

  rx_sync_ctrl #(
    .SYNC_COMS   (SYNC_COMS),
    .LOSS_CYCLES (LOSS_CYCLES),
    .COM         (COM)
  ) dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .enable      (enable),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .sync_active (sync_active),
    .idle        (idle),
    .state       (state),
    .loss_cnt    (loss_cnt)
  );

  always #5 clk_4f = ~clk_4f;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entry: {state, sync_active, idle, valid_out, data_out, loss_cnt}
  logic [16:0] sb[$];
  logic [16:0] exp_v;
  logic [16:0] got_v;

  // Model state
  int         m_state, m_com, m_gap, m_loss;
  logic [7:0] m_dout;
  logic       m_vout, m_idle, m_sync;

  function automatic logic [16:0] observe();
    return {state, sync_active, idle, valid_out, data_out, loss_cnt};
  endfunction

  function automatic logic [3:0] loss_vis(input int l);
`ifdef RX_SYNC_LOSSCNT_EN
    return 4'(l);
`else
    return 4'(l * 0);
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_com = 0; m_gap = 0; m_loss = 0;
    m_dout = 8'h00; m_vout = 0; m_idle = 0; m_sync = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic en, input logic v, input logic [7:0] d);
    logic c;
    int ns, nc, ng, nl;
    logic ni;
    c  = v && (d == COM);
    ns = m_state; nc = m_com; ng = m_gap; nl = m_loss; ni = m_idle;
    m_vout = 0;
    if (!en) begin
      ns = 0; nc = 0; ng = 0; ni = 0;
    end else if (m_state == 0) begin
      ni = 0;
      if (c) begin
        if (SYNC_COMS == 1) begin ns = 2; nc = 0; end
        else begin ns = 1; nc = 1; end
      end
    end else if (m_state == 1) begin
      ni = 0;
      if (v && !c) begin ns = 0; nc = 0; end
      else if (c) begin
        if (m_com + 1 == SYNC_COMS) begin ns = 2; nc = 0; end
        else nc = m_com + 1;
      end
    end else begin
      if (v) begin
        ng = 0;
        if (c) ni = 1;
        else begin m_vout = 1; m_dout = d; ni = 0; end
      end else if (m_gap + 1 == LOSS_CYCLES) begin
        ns = 0; ng = 0; ni = 0;
        if (m_loss < 15) nl = m_loss + 1;
      end else begin
        ng = m_gap + 1;
      end
    end
    m_state = ns; m_com = nc; m_gap = ng; m_loss = nl; m_idle = ni;
    m_sync = (ns == 2);
    sb.push_back({2'(m_state), m_sync, m_idle, m_vout, m_dout, loss_vis(m_loss)});
  endtask

  // Drive one byte (called at posedge+1), predict, then wait to posedge+1
  task automatic step(input logic en, input logic v, input logic [7:0] d);
    enable = en; valid_in = v; data_in = d;
    model_step(en, v, d);
    $display("txn t=%0t en=%0b v=%0b d=%02h", $time, en, v, d);
    @(posedge clk_4f);
    #1;
  endtask

  // Reset and release; leaves the bench at posedge+1 with DUT in SEARCH
  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk_4f);
    #1;
    got_v = observe();
    n_checks++;
    if (got_v !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", got_v, 17'h0);
    end
    reset = 1'b1;
  endtask

  task automatic test_sync();
    logic [1:0] exp_st [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      step(1, 1, COM);
      exp_v = sb.pop_front();
      got_v = observe();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL sync_sb[%0d] got=%h exp=%h", i, got_v, exp_v);
      end
      n_checks++;
      if (state !== exp_st[i] || valid_out !== 1'b0 || sync_active !== (i == 3)) begin
        n_fail++;
        $display("FAIL sync_state[%0d] got st=%0d vo=%0b sa=%0b exp st=%0d vo=0 sa=%0b",
                 i, state, valid_out, sync_active, exp_st[i], (i == 3));
      end
    end
  endtask

  task automatic test_forward();
    logic [7:0] bytes [3] = '{8'h11, 8'hBC, 8'h22};
    for (int i = 0; i < 3; i++) begin
      step(1, 1, bytes[i]);
      exp_v = sb.pop_front();
      got_v = observe();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL fwd_sb[%0d] got=%h exp=%h", i, got_v, exp_v);
      end
    end
    // Last byte 8'h22 forwarded with idle cleared
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h22 || idle !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_last got vo=%0b do=%02h idle=%0b exp vo=1 do=22 idle=0",
               valid_out, data_out, idle);
    end
  endtask

  task automatic test_count_break();
    logic [7:0] bytes [4] = '{8'hBC, 8'hBC, 8'h55, 8'hBC};
    logic [1:0] exp_st [4] = '{2'd1, 2'd1, 2'd0, 2'd1};
    step(0, 0, 8'h00);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      step(1, 1, bytes[i]);
      exp_v = sb.pop_front();
      got_v = observe();
      n_checks++;
      if (got_v !== exp_v || state !== exp_st[i]) begin
        n_fail++;
        $display("FAIL cnt_break[%0d] got=%h exp=%h st_exp=%0d", i, got_v, exp_v, exp_st[i]);
      end
    end
  endtask

  task automatic sync_up();
    step(0, 0, 8'h00);
    for (int i = 0; i < SYNC_COMS; i++) step(1, 1, COM);
  endtask

  task automatic test_loss();
    for (int r = 0; r < 20; r++) begin
      sync_up();
      for (int i = 0; i < LOSS_CYCLES; i++) step(1, 0, 8'h00);
      while (sb.size() > 0) begin
        exp_v = sb.pop_front();
        if (sb.size() == 0) begin
          got_v = observe();
          n_checks++;
          if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL loss_sb[%0d] got=%h exp=%h", r, got_v, exp_v);
          end
        end
      end
      n_checks++;
      if (state !== 2'd0 || sync_active !== 1'b0 ||
          loss_cnt !== loss_vis((r + 1 > 15) ? 15 : r + 1)) begin
        n_fail++;
        $display("FAIL loss_evt[%0d] got st=%0d sa=%0b lc=%0d exp st=0 sa=0 lc=%0d",
                 r, state, sync_active, loss_cnt, loss_vis((r + 1 > 15) ? 15 : r + 1));
      end
    end
  endtask

  task automatic test_no_loss();
    sync_up();
    sb.delete();
    for (int i = 0; i < LOSS_CYCLES - 1; i++) step(1, 0, 8'h00);
    step(1, 1, 8'h33);
    for (int i = 0; i < LOSS_CYCLES - 1; i++) step(1, 0, 8'h00);
    for (int i = 0; sb.size() > 0; i++) begin
      exp_v = sb.pop_front();
      if (i == LOSS_CYCLES - 1 || sb.size() == 0) begin
        got_v = (sb.size() == 0) ? observe() : exp_v;
      end
    end
    n_checks++;
    if (got_v !== exp_v || state !== 2'd2 || sync_active !== 1'b1) begin
      n_fail++;
      $display("FAIL no_loss got=%h exp=%h st=%0d", got_v, exp_v, state);
    end
  endtask

  task automatic test_enable();
    int loss_before;
    // Disable during COUNT
    step(0, 0, 8'h00);
    step(1, 1, COM);
    step(1, 1, COM);
    sb.delete();
    step(0, 1, COM);
    exp_v = sb.pop_front();
    got_v = observe();
    n_checks++;
    if (got_v !== exp_v || state !== 2'd0) begin
      n_fail++;
      $display("FAIL en_count got=%h exp=%h", got_v, exp_v);
    end
    // Disable during ACTIVE, coinciding with the loss threshold
    sync_up();
    for (int i = 0; i < LOSS_CYCLES - 1; i++) step(1, 0, 8'h00);
    sb.delete();
    loss_before = m_loss;
    step(0, 0, 8'h00);
    exp_v = sb.pop_front();
    got_v = observe();
    n_checks++;
    if (got_v !== exp_v || state !== 2'd0 || loss_cnt !== loss_vis(loss_before)) begin
      n_fail++;
      $display("FAIL en_active got=%h exp=%h lc=%0d exp_lc=%0d",
               got_v, exp_v, loss_cnt, loss_vis(loss_before));
    end
  endtask

  task automatic test_async_reset();
    sync_up();
    step(1, 1, 8'h5A);
    sb.delete();
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h5A) begin
      n_fail++;
      $display("FAIL pre_rst got vo=%0b do=%02h exp vo=1 do=5a", valid_out, data_out);
    end
    valid_in = 1'b1; data_in = 8'h77;
    #2;
    reset = 1'b0;
    #1;
    got_v = observe();
    n_checks++;
    if (got_v !== 17'h0) begin
      n_fail++;
      $display("FAIL async_rst got=%h exp=%h", got_v, 17'h0);
    end
    @(posedge clk_4f);
    #1;
    got_v = observe();
    n_checks++;
    if (got_v !== 17'h0) begin
      n_fail++;
      $display("FAIL rst_hold got=%h exp=%h", got_v, 17'h0);
    end
    model_reset();
    reset = 1'b1;
    valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sync();
    test_forward();
    test_count_break();
    test_loss();
    test_no_loss();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_sync_ctrl.md
Name: rx_sync_ctrl

Overview:
- Lane-alignment controller placed in front of the phy_rx two-level byte demux.
- Watches the incoming byte stream and declares sync after SYNC_COMS consecutive valid COM symbols.
- After sync, forwards only data bytes (COM stripped) with a registered valid to the demux chain.
- Drops sync after LOSS_CYCLES consecutive cycles without valid input, counts sync losses, and exposes state/idle status to the PHY top.

Parameters:
- SYNC_COMS, 4, consecutive valid COM bytes needed to enter ACTIVE; legal range 1..15.
- LOSS_CYCLES, 16, consecutive cycles with valid_in=0 in ACTIVE that force loss of sync; legal range 2..255.
- COM, 8'hBC, alignment/idle symbol value.

Ports:
- clk_4f  in  1  byte-rate clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  synchronous enable; 0 forces SEARCH next cycle.
- data_in  in  8  incoming byte.
- valid_in  in  1  data_in qualifier.
- data_out  out  8  byte to demux; registered.
- valid_out  out  1  data_out qualifier; registered.
- sync_active  out  1  1 while state is ACTIVE.
- idle  out  1  1 in ACTIVE when the last valid byte was COM.
- state  out  2  encoded FSM state: SEARCH=0, COUNT=1, ACTIVE=2.
- loss_cnt  out  4  saturating count of ACTIVE->SEARCH loss events.

Behaviour:
- Reset (reset=0, async): state=SEARCH, com_cnt=0, gap_cnt=0, data_out=8'h00, valid_out=0, sync_active=0, idle=0, loss_cnt=0. Deassertion takes effect at the next clk_4f edge.
- All outputs are registered. data_out/valid_out latency is 1 cycle from data_in/valid_in.
- SEARCH: valid_out=0.
  - valid_in=1 && data_in==COM -> COUNT, com_cnt=1. If SYNC_COMS==1, go directly to ACTIVE.
  - Any other input -> stay in SEARCH.
- COUNT: valid_out=0.
  - valid COM -> com_cnt+1; when com_cnt+1==SYNC_COMS -> ACTIVE, com_cnt=0.
  - valid non-COM -> SEARCH, com_cnt=0.
  - valid_in=0 -> hold state and com_cnt (gaps do not break the run).
- ACTIVE:
  - valid non-COM: valid_out=1, data_out=data_in, idle=0.
  - valid COM: valid_out=0, data_out holds, idle=1.
  - valid_in=0: valid_out=0, gap_cnt+1.
  - Any valid byte clears gap_cnt to 0.
  - When gap_cnt+1==LOSS_CYCLES (on a valid_in=0 cycle): next state SEARCH, loss_cnt+1 (saturates at 15), gap_cnt=0, idle=0.
- sync_active is registered and equals (next state==ACTIVE), so it rises in the same cycle as the first forwarded-eligible byte.
- enable=0 (checked first, overrides all other transitions): next state SEARCH; com_cnt, gap_cnt, valid_out and idle cleared. loss_cnt is not incremented and is cleared only by reset.
- Simultaneous events:
  - Loss threshold and enable=0 in the same cycle: enable wins; no loss is counted.
  - Valid COM on the cycle sync is achieved: that COM is not forwarded.
- Reset asserted mid-stream returns everything to reset values immediately; no partial byte is emitted.

Optional Feature:
- Macro RX_SYNC_LOSSCNT_EN.
- Defined: loss_cnt behaves as described above.
- Undefined: the counter logic is not built and loss_cnt is tied to 4'h0. All other behaviour is identical.

Decomposition:
- Shared package rx_sync_pkg:
  - state encoding localparams ST_SEARCH=2'd0, ST_COUNT=2'd1, ST_ACTIVE=2'd2;
  - COM default 8'hBC.
- The package is also used by the phy_rx top-level status logic.
- One natural sub-module, sat_counter (parameterised width, inc, clr, saturate at all-ones). It is instantiated for loss_cnt and gap_cnt; com_cnt is kept inline.

Test Plan:
- Reset then 4 valid 8'hBC bytes -> state 0->1->1->1->2; sync_active=1 on the cycle after the 4th COM; valid_out stays 0.
- Sync achieved, then bytes 8'h11, 8'hBC, 8'h22 -> one cycle later valid_out=1 with data_out=8'h11; next cycle valid_out=0 with idle=1; next cycle valid_out=1 with data_out=8'h22 and idle=0.
- COM, COM, 8'h55, COM in COUNT -> return to SEARCH on 8'h55; the final COM restarts at com_cnt=1; state=1, not ACTIVE.
- In ACTIVE, hold valid_in=0 for 16 cycles -> state=SEARCH after the 16th, loss_cnt=1, sync_active=0. Repeat 20 times -> loss_cnt saturates at 4'hF.
- In ACTIVE, 15 idle cycles then one valid byte then 15 idle cycles -> no loss; gap_cnt restarts on the valid byte.
- enable=0 during COUNT and again during ACTIVE -> SEARCH next cycle, loss_cnt unchanged. Assert reset mid-byte -> all outputs 0 asynchronously.
- Build without RX_SYNC_LOSSCNT_EN -> loss scenario leaves loss_cnt=0; all other checks pass.
